dsp_div_signed_seq_neg: RTL and testbench

//  Sequential signed divider; the inverse of the negedge signed MAC datapath (P = A*B).

---
 rtl/dsp_div_signed_seq_neg.sv | 191 +++++++++++++++++++
 tb/tb_dsp_div_signed_seq_neg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dsp_div_signed_seq_neg.sv
// Sequential signed restoring divider, falling-edge clocked.
// Divides a P_W-bit signed dividend by a B_W-bit signed divisor. The quotient
// is truncated toward zero and saturated to A_W bits. The remainder takes the
// sign of the dividend. One quotient bit is produced per falling edge, MSB first.
module dsp_div_signed_seq_neg #(
  parameter int A_W = 20,
  parameter int B_W = 18,
  parameter int P_W = 38
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [P_W-1:0] dividend,
  input  logic [B_W-1:0] divisor,
  output logic [A_W-1:0] quotient,
  output logic [B_W-1:0] remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CNT_W = $clog2(P_W);

  // Largest quotient magnitudes representable in A_W signed bits
  localparam logic [P_W-1:0] Q_POS_LIM = (P_W'(1) << (A_W - 1)) - P_W'(1);
  localparam logic [P_W-1:0] Q_NEG_LIM = P_W'(1) << (A_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // r_dvd starts as |dividend|. It shifts left each step, and quotient bits enter at the LSB.
  logic [P_W-1:0]   r_dvd;
  logic [P_W-1:0]   w_dvd_next;
  logic [B_W-1:0]   r_dvs;
  logic [B_W-1:0]   w_dvs_next;
  logic [B_W:0]     r_rem;
  logic [B_W:0]     w_rem_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_sign_q;
  logic             w_sign_q_next;
  logic             r_sign_r;
  logic             w_sign_r_next;

  logic [A_W-1:0]   r_quot;
  logic [A_W-1:0]   w_quot_next;
  logic [B_W-1:0]   r_remo;
  logic [B_W-1:0]   w_remo_next;
  logic             r_busy;
  logic             w_busy_next;
  logic             r_done;
  logic             w_done_next;
  logic             r_dbz;
  logic             w_dbz_next;
  logic             r_ovf;
  logic             w_ovf_next;

  // Operand magnitudes. Negating the most negative value wraps to the correct unsigned magnitude.
  logic [P_W-1:0]   w_dvd_abs;
  logic [B_W-1:0]   w_dvs_abs;
  // Restoring step. The trial value is one bit wider than r_rem, so the compare never loses the carry.
  logic [B_W+1:0]   w_trial;
  logic             w_ge;
  logic [B_W:0]     w_diff;
  // Final sign correction and range check
  logic             w_q_ovf;
  logic [A_W-1:0]   w_q_signed;
  logic [B_W-1:0]   w_r_signed;

  assign w_dvd_abs  = dividend[P_W-1] ? (~dividend + P_W'(1)) : dividend;
  assign w_dvs_abs  = divisor[B_W-1]  ? (~divisor + B_W'(1))  : divisor;
  assign w_trial    = {r_rem, r_dvd[P_W-1]};
  assign w_ge       = (w_trial >= {2'b00, r_dvs});
  assign w_diff     = w_trial[B_W:0] - {1'b0, r_dvs};
  assign w_q_ovf    = r_sign_q ? (r_dvd > Q_NEG_LIM) : (r_dvd > Q_POS_LIM);
  assign w_q_signed = r_sign_q ? (~r_dvd[A_W-1:0] + A_W'(1)) : r_dvd[A_W-1:0];
  assign w_r_signed = r_sign_r ? (~r_rem[B_W-1:0] + B_W'(1)) : r_rem[B_W-1:0];

  // Next-state and datapath logic for the IDLE -> CALC -> FIX sequence
  always_comb begin
    w_state_next  = r_state;
    w_dvd_next    = r_dvd;
    w_dvs_next    = r_dvs;
    w_rem_next    = r_rem;
    w_cnt_next    = r_cnt;
    w_sign_q_next = r_sign_q;
    w_sign_r_next = r_sign_r;
    w_quot_next   = r_quot;
    w_remo_next   = r_remo;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    w_dbz_next    = r_dbz;
    w_ovf_next    = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_dvd_next    = w_dvd_abs;
          w_dvs_next    = w_dvs_abs;
          w_rem_next    = '0;
          w_cnt_next    = CNT_W'(P_W - 1);
          w_sign_q_next = dividend[P_W-1] ^ divisor[B_W-1];
          w_sign_r_next = dividend[P_W-1];
          w_busy_next   = 1'b1;
          w_dbz_next    = 1'b0;
          w_ovf_next    = 1'b0;
          // A zero divisor skips the iterations entirely
          w_state_next  = (divisor == '0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        w_rem_next   = w_ge ? w_diff : w_trial[B_W:0];
        w_dvd_next   = {r_dvd[P_W-2:0], w_ge};
        w_cnt_next   = r_cnt - CNT_W'(1);
        if (r_cnt == '0) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        w_busy_next  = 1'b0;
        w_done_next  = 1'b1;
        w_state_next = S_IDLE;
        if (r_dvs == '0) begin
          w_quot_next = '0;
          w_remo_next = '0;
          w_dbz_next  = 1'b1;
          w_ovf_next  = 1'b0;
        end else begin
          w_remo_next = w_r_signed;
          w_dbz_next  = 1'b0;
          w_ovf_next  = w_q_ovf;
          if (w_q_ovf) begin
            w_quot_next = r_sign_q ? {1'b1, {(A_W-1){1'b0}}} : {1'b0, {(A_W-1){1'b1}}};
          end else begin
            w_quot_next = w_q_signed;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // All state updates on the falling edge. Reset aborts any operation in flight.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_quot   <= '0;
      r_remo   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_dvd    <= w_dvd_next;
      r_dvs    <= w_dvs_next;
      r_rem    <= w_rem_next;
      r_cnt    <= w_cnt_next;
      r_sign_q <= w_sign_q_next;
      r_sign_r <= w_sign_r_next;
      r_quot   <= w_quot_next;
      r_remo   <= w_remo_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      r_dbz    <= w_dbz_next;
      r_ovf    <= w_ovf_next;
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_dsp_div_signed_seq_neg.sv
// Directed and model-checked bench for the falling-edge signed divider.
// Inputs are driven and outputs are sampled on the rising edge, away from the DUT's active edge.
module tb_dsp_div_signed_seq_neg;

  localparam int A_W = 20;
  localparam int B_W = 18;
  localparam int P_W = 38;

  logic           clk;
  logic           reset;
  logic           start;
  logic [P_W-1:0] dividend;
  logic [B_W-1:0] divisor;
  logic [A_W-1:0] quotient;
  logic [B_W-1:0] remainder;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic           overflow;

  int n_tests = 0;
  int n_fail  = 0;

  dsp_div_signed_seq_neg #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [63:0] act,
                           input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One division. With noise set, extra start pulses with different operands are sent while busy.
  task automatic run_div(input string tag, input longint dvd, input longint dvs,
                         input longint eq, input longint er,
                         input logic edbz, input logic eovf, input bit noise);
    int n;
    int bcnt;
    int exp_lat;
    bit seen;
    @(posedge clk);
    dividend = dvd[P_W-1:0];
    divisor  = dvs[B_W-1:0];
    start    = 1'b1;
    n    = 0;
    bcnt = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      if (noise && (n == 5 || n == 20)) begin
        start    = 1'b1;
        dividend = ~dividend;
        divisor  = divisor + 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
    end
    exp_lat = edbz ? 2 : P_W + 2;
    check_val({tag, ".done_seen"}, 64'(seen), 64'sd1);
    if (!seen) return;
    check_val({tag, ".latency"}, 64'(n), 64'(exp_lat));
    check_val({tag, ".busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
    check_val({tag, ".busy_at_done"}, 64'(busy), 64'sd0);
    check_val({tag, ".quotient"}, $signed(quotient), eq);
    check_val({tag, ".remainder"}, $signed(remainder), er);
    check_val({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(edbz));
    check_val({tag, ".overflow"}, 64'(overflow), 64'(eovf));
    $display("[TB] %s: %0d / %0d -> q=%0d r=%0d dbz=%0b ovf=%0b (lat %0d)",
             tag, dvd, dvs, $signed(quotient), $signed(remainder),
             div_by_zero, overflow, n);
    @(posedge clk);
    check_val({tag, ".done_pulse"}, 64'(done), 64'sd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [A_W-1:0] a;
    logic signed [B_W-1:0] b;
    logic signed [P_W-1:0] d38;
    logic [63:0] rr;
    longint d, q, r;
    logic ov;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    check_val("rst.quotient", $signed(quotient), 64'sd0);
    check_val("rst.remainder", $signed(remainder), 64'sd0);
    check_val("rst.busy", 64'(busy), 64'sd0);
    check_val("rst.done", 64'(done), 64'sd0);
    check_val("rst.div_by_zero", 64'(div_by_zero), 64'sd0);
    check_val("rst.overflow", 64'(overflow), 64'sd0);
    $display("[TB] reset: q=%0d r=%0d busy=%0b done=%0b", $signed(quotient),
             $signed(remainder), busy, done);
    reset = 1'b0;

    // Directed vectors
    run_div("10/2",   10,  2,  5,  0, 1'b0, 1'b0, 1'b0);
    run_div("-7/2",   -7,  2, -3, -1, 1'b0, 1'b0, 1'b0);
    run_div("7/-2",    7, -2, -3,  1, 1'b0, 1'b0, 1'b0);
    run_div("-7/-2",  -7, -2,  3, -1, 1'b0, 1'b0, 1'b0);
    run_div("100/-7", 100, -7, -14, 2, 1'b0, 1'b0, 1'b0);
    run_div("minmin", -(longint'(1) << 37), -(longint'(1) << 17), 524287, 0,
            1'b0, 1'b1, 1'b0);
    run_div("dbz",    1234, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    run_div("pos_sat", 524288, 1, 524287, 0, 1'b0, 1'b1, 1'b0);
    run_div("neg_edge", -524288, 1, -524288, 0, 1'b0, 1'b0, 1'b0);
    run_div("neg_sat", -524289, 1, -524288, 0, 1'b0, 1'b1, 1'b0);
    run_div("ovf_rem", 1048579, 2, 524287, 1, 1'b0, 1'b1, 1'b0);
    run_div("noise",  -1000, 7, -142, -6, 1'b0, 1'b0, 1'b1);

    // Products of MAC operands must divide back exactly
    for (int i = 0; i < 32; i++) begin
      a = A_W'($urandom);
      do b = B_W'($urandom); while (b == '0);
      d = longint'(a) * longint'(b);
      run_div("mac", d, longint'(b), longint'(a), 0, 1'b0, 1'b0, 1'b0);
    end

    // Random pairs against the language's truncating / and %
    for (int i = 0; i < 32; i++) begin
      rr  = {$urandom(), $urandom()};
      d38 = rr[P_W-1:0];
      d   = longint'(d38) >>> $urandom_range(0, P_W - 1);
      do b = B_W'($urandom); while (b == '0);
      q  = d / longint'(b);
      r  = d % longint'(b);
      ov = 1'b0;
      if (q > 524287) begin
        q  = 524287;
        ov = 1'b1;
      end else if (q < -524288) begin
        q  = -524288;
        ov = 1'b1;
      end
      run_div("rand", d, longint'(b), q, r, 1'b0, ov, 1'b0);
    end

    // Reset in the middle of CALC
    @(posedge clk);
    dividend = P_W'(1000);
    divisor  = B_W'(3);
    start    = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    reset = 1'b1;
    #1;
    check_val("abort.busy", 64'(busy), 64'sd0);
    check_val("abort.done", 64'(done), 64'sd0);
    check_val("abort.quotient", $signed(quotient), 64'sd0);
    check_val("abort.remainder", $signed(remainder), 64'sd0);
    repeat (2) @(posedge clk);
    check_val("abort.no_done", 64'(done), 64'sd0);
    $display("[TB] abort: busy=%0b done=%0b q=%0d", busy, done, $signed(quotient));
    reset = 1'b0;
    run_div("after_abort", 1000, 3, 333, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
